shape_raster_engine: RTL and testbench

- Parametrised bounding-box rasteriser: reads a scene (shape count plus shape records) from byte-wide external memory and writes a row-major framebuffer of IMG_W x IMG_H pixels back to the same memory.
- Generalises the single-shape, x-only engine to:
  - full 2-D inclusive boxes
  - any number of shapes, with painter's order (last hit wins)
  - configurable colour depth and image size
  - a proper valid/ready memory request port with variable read latency
- Sits between the top-level pad mux and the external SPI/parallel memory bridge.

---
 rtl/shape_raster_engine_pkg.sv | 34 +++
 rtl/shape_raster_engine_if.sv | 25 ++
 rtl/shape_raster_engine_mem_port.sv | 59 +++++
 rtl/shape_raster_engine.sv | 185 ++++++++++++++++++
 tb/tb_shape_raster_engine.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shape_raster_engine_pkg.sv
// Shared types for the shape rasteriser: FSM states, bounding-box record
// layout and the scene record stride.
package raster_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_WT,
    S_PIX_INIT,
    S_BB_RD,
    S_BB_WT,
    S_TEST,
    S_COL_RD,
    S_COL_WT,
    S_NEXT_SHAPE,
    S_WR,
    S_NEXT_PIX,
    S_DONE
  } state_t;

  localparam int BBOX_BYTES = 4;

  typedef struct packed {
    logic [7:0] x0;
    logic [7:0] y0;
    logic [7:0] x1;
    logic [7:0] y1;
  } bbox_t;

  function automatic int stride(input int colour_bytes);
    return BBOX_BYTES + colour_bytes;
  endfunction

endpackage

// File: rtl/shape_raster_engine_if.sv
// Byte-wide valid/ready memory request port with a separate read-response
// strobe, shared by the rasteriser (master) and the memory bridge (slave).
interface shape_raster_engine_if #(
  parameter int ADDR_W = 24
);

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [7:0]        mem_req_wdata;
  logic              mem_rsp_valid;
  logic [7:0]        mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

endinterface

// File: rtl/shape_raster_engine_mem_port.sv
// Request register stage for the rasteriser: holds one request stable until
// accepted and tracks the single read allowed in flight.
module raster_mem_port #(
  parameter int ADDR_W = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shape_raster_engine_if.master mem,
  input  logic                  i_issue,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [7:0]            i_wdata,
  output logic                  o_free,
  output logic                  o_accepted,
  output logic                  o_rdata_valid,
  output logic [7:0]            o_rdata
);

  logic              r_valid;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_rd_out;
  logic              w_free;

  assign w_free        = !r_valid && !r_rd_out;
  assign o_free        = w_free;
  assign o_accepted    = r_valid && mem.mem_req_ready;
  assign o_rdata_valid = r_rd_out && mem.mem_rsp_valid;
  assign o_rdata       = mem.mem_rsp_data;

  assign mem.mem_req_valid = r_valid;
  assign mem.mem_req_we    = r_we;
  assign mem.mem_req_addr  = r_addr;
  assign mem.mem_req_wdata = r_wdata;

  // A response without a read in flight is dropped by the r_rd_out gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rd_out <= 1'b0;
    end else begin
      if (r_valid && mem.mem_req_ready) begin
        r_valid <= 1'b0;
        if (!r_we) r_rd_out <= 1'b1;
      end else if (i_issue && w_free) begin
        r_valid <= 1'b1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (r_rd_out && mem.mem_rsp_valid) r_rd_out <= 1'b0;
    end
  end

endmodule

// File: rtl/shape_raster_engine.sv
// Bounding-box rasteriser: walks every pixel, re-reads the scene's boxes for
// each one, and writes the winning colour (last hit, else background).
module shape_raster_engine
  import raster_pkg::*;
#(
  parameter int                ADDR_W       = 24,
  parameter int                IMG_W        = 16,
  parameter int                IMG_H        = 16,
  parameter int                COLOUR_BYTES = 3,
  parameter logic [ADDR_W-1:0] SCENE_BASE   = '0,
  parameter logic [ADDR_W-1:0] FB_BASE      = ADDR_W'(24'h800000),
  parameter logic [31:0]       BG_COLOUR    = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  shape_raster_engine_if.master mem
);

  localparam logic [7:0]        X_LAST   = 8'(IMG_W - 1);
  localparam logic [7:0]        Y_LAST   = 8'(IMG_H - 1);
  localparam logic [1:0]        CB_LAST  = 2'(COLOUR_BYTES - 1);
  localparam logic [1:0]        BB_LAST  = 2'(BBOX_BYTES - 1);
  localparam logic [ADDR_W-1:0] COL_SKIP = ADDR_W'(stride(COLOUR_BYTES) - BBOX_BYTES);

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_n;
  logic [7:0]        r_shape;
  logic [7:0]        r_x;
  logic [7:0]        r_y;
  logic [1:0]        r_byte;
  bbox_t             r_bbox;
  logic [31:0]       r_colour;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_fb_ptr;

  logic              w_issue;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic              w_free;
  logic              w_accepted;
  logic              w_rdata_valid;
  logic [7:0]        w_rdata;
  logic              w_hit;
  logic [7:0]        w_colour_byte;

  raster_mem_port #(.ADDR_W(ADDR_W)) u_mem_port (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem           (mem),
    .i_issue       (w_issue),
    .i_we          (w_we),
    .i_addr        (w_addr),
    .i_wdata       (w_wdata),
    .o_free        (w_free),
    .o_accepted    (w_accepted),
    .o_rdata_valid (w_rdata_valid),
    .o_rdata       (w_rdata)
  );

  // Inverted boxes fail one of the two range compares and so never hit.
  assign w_hit = (r_x >= r_bbox.x0) && (r_x <= r_bbox.x1) &&
                 (r_y >= r_bbox.y0) && (r_y <= r_bbox.y1);
  assign w_colour_byte = r_colour[{r_byte, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_we    = 1'b0;
    w_addr  = r_rd_ptr;
    w_wdata = '0;
    busy    = (r_state != S_IDLE) && (r_state != S_DONE);
    done    = (r_state == S_DONE);
    case (r_state)
      S_IDLE:       if (start) w_next = S_HDR_RD;
      S_HDR_RD: begin
        w_issue = 1'b1;
        w_addr  = SCENE_BASE;
        if (w_free) w_next = S_HDR_WT;
      end
      S_HDR_WT:     if (w_rdata_valid) w_next = S_PIX_INIT;
      S_PIX_INIT:   w_next = (r_n == 8'd0) ? S_WR : S_BB_RD;
      S_BB_RD: begin
        w_issue = 1'b1;
        if (w_free) w_next = S_BB_WT;
      end
      S_BB_WT:
        if (w_rdata_valid) w_next = (r_byte == BB_LAST) ? S_TEST : S_BB_RD;
      S_TEST:       w_next = w_hit ? S_COL_RD : S_NEXT_SHAPE;
      S_COL_RD: begin
        w_issue = 1'b1;
        if (w_free) w_next = S_COL_WT;
      end
      S_COL_WT:
        if (w_rdata_valid) w_next = (r_byte == CB_LAST) ? S_NEXT_SHAPE : S_COL_RD;
      S_NEXT_SHAPE: w_next = (r_shape == r_n - 8'd1) ? S_WR : S_BB_RD;
      S_WR: begin
        w_issue = 1'b1;
        w_we    = 1'b1;
        w_addr  = r_fb_ptr;
        w_wdata = w_colour_byte;
        if (w_accepted && r_byte == CB_LAST) w_next = S_NEXT_PIX;
      end
      S_NEXT_PIX:   w_next = (r_x == X_LAST && r_y == Y_LAST) ? S_DONE : S_PIX_INIT;
      S_DONE:       w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Scene pointer walks the records linearly; a miss skips the colour bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_shape  <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_byte   <= '0;
      r_bbox   <= '0;
      r_colour <= '0;
      r_rd_ptr <= '0;
      r_fb_ptr <= '0;
    end else begin
      case (r_state)
        S_HDR_WT:
          if (w_rdata_valid) begin
            r_n      <= w_rdata;
            r_x      <= '0;
            r_y      <= '0;
            r_fb_ptr <= FB_BASE;
          end
        S_PIX_INIT: begin
          r_shape  <= '0;
          r_colour <= BG_COLOUR;
          r_rd_ptr <= SCENE_BASE + ADDR_W'(1);
          r_byte   <= '0;
        end
        S_BB_WT:
          if (w_rdata_valid) begin
            case (r_byte)
              2'd0:    r_bbox.x0 <= w_rdata;
              2'd1:    r_bbox.y0 <= w_rdata;
              2'd2:    r_bbox.x1 <= w_rdata;
              default: r_bbox.y1 <= w_rdata;
            endcase
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_byte   <= (r_byte == BB_LAST) ? 2'd0 : r_byte + 2'd1;
          end
        S_TEST: begin
          r_byte <= '0;
          if (!w_hit) r_rd_ptr <= r_rd_ptr + COL_SKIP;
        end
        S_COL_WT:
          if (w_rdata_valid) begin
            r_colour[{r_byte, 3'b000} +: 8] <= w_rdata;
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_byte   <= (r_byte == CB_LAST) ? 2'd0 : r_byte + 2'd1;
          end
        S_NEXT_SHAPE: r_shape <= r_shape + 8'd1;
        S_WR:
          if (w_accepted) begin
            r_fb_ptr <= r_fb_ptr + ADDR_W'(1);
            r_byte   <= (r_byte == CB_LAST) ? 2'd0 : r_byte + 2'd1;
          end
        S_NEXT_PIX:
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= r_y + 8'd1;
          end else begin
            r_x <= r_x + 8'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_raster_engine.sv
// Scoreboard bench for shape_raster_engine: a 4x4x3-byte instance behind a
// random-stall memory model and a 256x1x1-byte instance behind a simple one.
module tb_shape_raster_engine;

  localparam int          W_A   = 4;
  localparam int          H_A   = 4;
  localparam int          CB_A  = 3;
  localparam logic [31:0] BG_A  = 32'h00123456;
  localparam logic [23:0] FB_A  = 24'h800000;
  localparam logic [23:0] SC_B  = 24'h000100;
  localparam logic [23:0] FB_B  = 24'hFFFF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, startA, busyA, doneA, startB, busyB, doneB;

  shape_raster_engine_if #(.ADDR_W(24)) busA ();
  shape_raster_engine_if #(.ADDR_W(24)) busB ();

  shape_raster_engine #(
    .ADDR_W(24), .IMG_W(W_A), .IMG_H(H_A), .COLOUR_BYTES(CB_A),
    .SCENE_BASE(24'h000000), .FB_BASE(FB_A), .BG_COLOUR(BG_A)
  ) dutA (
    .clk(clk), .rst_n(rstN), .start(startA), .busy(busyA), .done(doneA),
    .mem(busA.master)
  );

  shape_raster_engine #(
    .ADDR_W(24), .IMG_W(256), .IMG_H(1), .COLOUR_BYTES(1),
    .SCENE_BASE(SC_B), .FB_BASE(FB_B), .BG_COLOUR(32'h00000011)
  ) dutB (
    .clk(clk), .rst_n(rstN), .start(startB), .busy(busyB), .done(doneB),
    .mem(busB.master)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scene description and scoreboard state for instance A
  int          nShapes;
  logic [7:0]  sx0 [4];
  logic [7:0]  sy0 [4];
  logic [7:0]  sx1 [4];
  logic [7:0]  sy1 [4];
  logic [31:0] scol [4];
  logic [7:0]  memA [256];
  logic [31:0] qA [$];
  bit          randMode;
  int          pendCnt, readCount, wrCount, expReadsA;
  logic [7:0]  pendData;
  bit          readOut, stallPrev;
  logic [23:0] stallAddr;
  logic [8:0]  stallWeData;

  logic [7:0]  sceneB [16];
  logic [31:0] qB [$];
  bit          pendB;
  logic [7:0]  pendDataB;

  // Decisions made at the negedge describe the handshake at the next posedge.
  always @(negedge clk) begin : memModelA
    bit wasOut;
    logic [31:0] exp;
    if (!rstN) begin
      pendCnt = 0;
      readOut = 0;
      stallPrev = 0;
      busA.mem_rsp_valid = 1'b0;
      busA.mem_rsp_data = 8'h00;
      busA.mem_req_ready = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", 32'(busA.mem_req_valid), 32'd1);
        checkOutput("stall_addr", 32'(busA.mem_req_addr), 32'(stallAddr));
        checkOutput("stall_we_wdata", 32'({busA.mem_req_we, busA.mem_req_wdata}), 32'(stallWeData));
      end
      wasOut = readOut;
      busA.mem_rsp_valid = 1'b0;
      if (pendCnt > 0) begin
        pendCnt--;
        if (pendCnt == 0) begin
          busA.mem_rsp_valid = 1'b1;
          busA.mem_rsp_data = pendData;
          readOut = 0;
        end
      end else if (!readOut && randMode && $urandom_range(0, 7) == 0) begin
        busA.mem_rsp_valid = 1'b1;
        busA.mem_rsp_data = 8'hEE;
      end
      busA.mem_req_ready = randMode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (busA.mem_req_valid && busA.mem_req_ready) begin
        if (busA.mem_req_we) begin
          wrCount++;
          exp = (qA.size() > 0) ? qA.pop_front() : 32'hxxxxxxxx;
          checkOutput("fb_write_a", {busA.mem_req_addr, busA.mem_req_wdata}, exp);
        end else begin
          checkOutput("one_read_outstanding", 32'(wasOut), 32'd0);
          readCount++;
          readOut = 1;
          pendCnt = randMode ? int'($urandom_range(1, 7)) : 1;
          pendData = (busA.mem_req_addr < 24'd256) ? memA[busA.mem_req_addr[7:0]] : 8'h00;
        end
      end
      stallPrev = busA.mem_req_valid && !busA.mem_req_ready;
      stallAddr = busA.mem_req_addr;
      stallWeData = {busA.mem_req_we, busA.mem_req_wdata};
    end
  end

  always @(negedge clk) begin : memModelB
    logic [31:0] exp;
    logic [23:0] off;
    busB.mem_req_ready = 1'b1;
    busB.mem_rsp_valid = pendB;
    busB.mem_rsp_data = pendDataB;
    pendB = 0;
    if (rstN && busB.mem_req_valid) begin
      if (busB.mem_req_we) begin
        exp = (qB.size() > 0) ? qB.pop_front() : 32'hxxxxxxxx;
        checkOutput("fb_write_b", {busB.mem_req_addr, busB.mem_req_wdata}, exp);
      end else begin
        off = busB.mem_req_addr - SC_B;
        pendB = 1;
        pendDataB = (off < 24'd16) ? sceneB[off[3:0]] : 8'h00;
      end
    end
  end

  task automatic setShape(input int i, input int x0, input int y0, input int x1,
                          input int y1, input logic [31:0] col);
    sx0[i] = 8'(x0);
    sy0[i] = 8'(y0);
    sx1[i] = 8'(x1);
    sy1[i] = 8'(y1);
    scol[i] = col;
  endtask

  task automatic applyStimulus(input bit randomise);
    logic [31:0] c;
    logic [23:0] a;
    int reads, rec;
    for (int i = 0; i < 256; i++) memA[i] = 8'h00;
    memA[0] = 8'(nShapes);
    for (int i = 0; i < nShapes; i++) begin
      rec = 1 + i * (4 + CB_A);
      memA[rec] = sx0[i];
      memA[rec + 1] = sy0[i];
      memA[rec + 2] = sx1[i];
      memA[rec + 3] = sy1[i];
      for (int b = 0; b < CB_A; b++) memA[rec + 4 + b] = scol[i][8*b +: 8];
    end
    qA.delete();
    reads = 1;
    a = FB_A;
    for (int y = 0; y < H_A; y++) begin
      for (int x = 0; x < W_A; x++) begin
        c = BG_A;
        for (int i = 0; i < nShapes; i++) begin
          reads += 4;
          if (x >= int'(sx0[i]) && x <= int'(sx1[i]) && y >= int'(sy0[i]) && y <= int'(sy1[i])) begin
            c = scol[i];
            reads += CB_A;
          end
        end
        for (int b = 0; b < CB_A; b++) begin
          qA.push_back({a, c[8*b +: 8]});
          a = a + 24'd1;
        end
      end
    end
    expReadsA = reads;
    readCount = 0;
    wrCount = 0;
    randMode = randomise;
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    checkOutput("busy_after_start_a", 32'(busyA), 32'd1);
  endtask

  task automatic applyStimulusWide();
    for (int i = 0; i < 16; i++) sceneB[i] = 8'h00;
    sceneB[0] = 8'd1;
    sceneB[1] = 8'd250;
    sceneB[2] = 8'd0;
    sceneB[3] = 8'd255;
    sceneB[4] = 8'd0;
    sceneB[5] = 8'h5A;
    qB.delete();
    for (int x = 0; x < 256; x++)
      qB.push_back({FB_B + 24'(x), (x >= 250) ? 8'h5A : 8'h11});
    @(negedge clk);
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    checkOutput("busy_after_start_b", 32'(busyB), 32'd1);
  endtask

  // Also raises start during the DONE cycle, which must not begin a new frame.
  task automatic waitFrame(input bit useB, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 30000 && !seen; i++) begin
      @(negedge clk);
      if (useB ? doneB : doneA) seen = 1;
    end
    checkOutput({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, "_busy_at_done"}, 32'(useB ? busyB : busyA), 32'd0);
      checkOutput({tag, "_writes_left"}, 32'(useB ? qB.size() : qA.size()), 32'd0);
      if (!useB) checkOutput({tag, "_reads"}, 32'(readCount), 32'(expReadsA));
      if (useB) startB = 1'b1;
      else      startA = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      startB = 1'b0;
      checkOutput({tag, "_done_pulse"}, 32'(useB ? doneB : doneA), 32'd0);
      checkOutput({tag, "_start_in_done"}, 32'(useB ? busyB : busyA), 32'd0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busyA), 32'd0);
    checkOutput({tag, "_done"}, 32'(doneA), 32'd0);
    checkOutput({tag, "_valid"}, 32'(busA.mem_req_valid), 32'd0);
    checkOutput({tag, "_we"}, 32'(busA.mem_req_we), 32'd0);
    checkOutput({tag, "_addr"}, 32'(busA.mem_req_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(busA.mem_req_wdata), 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    randMode = 0;
    nShapes = 0;
    pendB = 0;
    pendDataB = 8'h00;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] empty scene, background only");
    nShapes = 0;
    applyStimulus(0);
    waitFrame(0, "bg");

    $display("[TB] single box, with a start pulse while busy");
    nShapes = 1;
    setShape(0, 1, 1, 2, 2, 32'h00AABBCC);
    applyStimulus(0);
    repeat (20) @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitFrame(0, "box");

    $display("[TB] overlapping boxes, painter's order");
    nShapes = 2;
    setShape(0, 0, 0, 3, 3, 32'h00FF0000);
    setShape(1, 2, 2, 3, 3, 32'h000000FF);
    applyStimulus(0);
    waitFrame(0, "overlap");

    $display("[TB] inverted box under random stalls and latency");
    nShapes = 1;
    setShape(0, 3, 0, 1, 3, 32'h0000FF00);
    applyStimulus(1);
    waitFrame(0, "inverted");

    $display("[TB] overlapping boxes under random stalls and latency");
    nShapes = 2;
    setShape(0, 0, 0, 3, 3, 32'h00FF0000);
    setShape(1, 2, 2, 3, 3, 32'h000000FF);
    applyStimulus(1);
    waitFrame(0, "overlap_rand");

    $display("[TB] 256-wide single-row image");
    applyStimulusWide();
    waitFrame(1, "wide");

    $display("[TB] reset during pixel 5 writes, then full frame");
    nShapes = 1;
    setShape(0, 1, 1, 2, 2, 32'h00AABBCC);
    applyStimulus(0);
    for (int i = 0; i < 5000 && wrCount < 16; i++) @(negedge clk);
    checkOutput("reached_pixel5", 32'(wrCount >= 16), 32'd1);
    #2 rstN = 1'b0;
    #1 checkResetOutputs("midreset");
    qA.delete();
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0);
    waitFrame(0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
